// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: PC, IR and req/ack instruction-memory reads.
// Define FETCH_TIMEOUT_EN to add a sticky ack-timeout flag with request retry.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | read request to imem at PC; a cycle with req low re-issues it
// EXEC  | IR presented to ctrl, waiting for instr_done
// HALT  | HLT retired, fetch stopped until reset
module sisc_fetch #(
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]        HALT_OP     = 4'hF,
   parameter int                TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              rst_f,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   output logic [31:0]       instruction,
   output logic              instr_valid,
   input  logic              instr_done,
   input  logic              br_taken,
   input  logic              br_rel,
   input  logic [15:0]       br_target,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic              fetch_err
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [31:0]       ir_q, ir_nxt;
   logic              valid_q, valid_nxt;
   logic              req_q, req_nxt;
   logic              halted_q, halted_nxt;

   // Branch target widened to 32 bits so any ADDR_W up to 32 slices cleanly;
   // the relative offset is sign-extended, the absolute target zero-extended.
   logic [31:0]       br_off32, br_abs32;
   assign br_off32 = {{16{br_target[15]}}, br_target};
   assign br_abs32 = {16'h0000, br_target};

`ifdef FETCH_TIMEOUT_EN
   localparam int TMR_W = ($clog2(TIMEOUT_CYC + 1) < 4) ? 4 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
   logic [TMR_W-1:0] tmr_q, tmr_nxt;
   logic             err_q, err_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
         halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tmr_q    <= TMR_LOAD;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_nxt;
         pc_q     <= pc_nxt;
         ir_q     <= ir_nxt;
         valid_q  <= valid_nxt;
         req_q    <= req_nxt;
         halted_q <= halted_nxt;
`ifdef FETCH_TIMEOUT_EN
         tmr_q    <= tmr_nxt;
         err_q    <= err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state_q;
      pc_nxt     = pc_q;
      ir_nxt     = ir_q;
      valid_nxt  = valid_q;
      req_nxt    = req_q;
      halted_nxt = halted_q;
`ifdef FETCH_TIMEOUT_EN
      tmr_nxt    = tmr_q;
      err_nxt    = err_q;
`endif
      case (state_q)
         FETCH: begin
            if (!req_q) begin
               // Issue cycle: after reset or a timeout back-off the request is raised here.
               req_nxt = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               tmr_nxt = TMR_LOAD;
`endif
            end else if (imem_ack) begin
               ir_nxt    = imem_data;
               pc_nxt    = pc_q + 1'b1;
               valid_nxt = 1'b1;
               req_nxt   = 1'b0;
               state_nxt = EXEC;
            end else begin
`ifdef FETCH_TIMEOUT_EN
               if (tmr_q == '0) begin
                  err_nxt = 1'b1;
                  req_nxt = 1'b0;
               end else begin
                  tmr_nxt = tmr_q - 1'b1;
               end
`endif
            end
         end
         EXEC: begin
            if (instr_done) begin
               valid_nxt = 1'b0;
               if (ir_q[31:28] == HALT_OP) begin
                  halted_nxt = 1'b1;
                  state_nxt  = HALT;
               end else begin
                  if (br_taken)
                     pc_nxt = br_rel ? pc_q + br_off32[ADDR_W-1:0] : br_abs32[ADDR_W-1:0];
                  req_nxt   = 1'b1;
                  state_nxt = FETCH;
`ifdef FETCH_TIMEOUT_EN
                  tmr_nxt   = TMR_LOAD;
`endif
               end
            end
         end
         HALT: begin
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
         end
         default: begin
            state_nxt = FETCH;
            req_nxt   = 1'b0;
         end
      endcase
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc_out      = pc_q;
   assign instruction = ir_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = err_q;
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: vector table for fetch/branch/wrap/halt,
// hand sequences for the halt hold-off, reset recovery and ack timeout.
module tb_sisc_fetch;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_done = 1'b0;
   logic        br_taken = 1'b0;
   logic        br_rel = 1'b0;
   logic [15:0] br_target = '0;
   logic [15:0] pc_out;
   logic        halted;
   logic        fetch_err;

   int errors = 0;
   int checks = 0;

   sisc_fetch dut (
      .clk(clk), .rst_f(rst_f),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .instruction(instruction), .instr_valid(instr_valid),
      .instr_done(instr_done), .br_taken(br_taken), .br_rel(br_rel), .br_target(br_target),
      .pc_out(pc_out), .halted(halted), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ack;
      logic [31:0] data;
      logic        done, bt, rel;
      logic [15:0] tgt;
      logic        req;
      logic [15:0] pc;
      logic [31:0] ir;
      logic        vld, hlt;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(logic rst, logic ack, logic [31:0] data, logic done, logic bt,
                               logic rel, logic [15:0] tgt, logic req, logic [15:0] pc,
                               logic [31:0] ir, logic vld, logic hlt);
      vec_t v;
      v.rst = rst; v.ack = ack; v.data = data; v.done = done; v.bt = bt; v.rel = rel;
      v.tgt = tgt; v.req = req; v.pc = pc; v.ir = ir; v.vld = vld; v.hlt = hlt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst ack data        done bt rel tgt     | req pc      ir           vld hlt
      vecs[0]  = mk(1, 0, 32'h0,        0, 0, 0, 16'h0000, 0, 16'h0000, 32'h0,        0, 0);
      vecs[1]  = mk(1, 1, 32'hDEADBEEF, 1, 1, 0, 16'h1234, 0, 16'h0000, 32'h0,        0, 0);
      vecs[2]  = mk(0, 0, 32'h0,        0, 0, 0, 16'h0000, 1, 16'h0000, 32'h0,        0, 0);
      vecs[3]  = mk(0, 1, 32'h11120001, 0, 0, 0, 16'h0000, 0, 16'h0001, 32'h11120001, 1, 0);
      vecs[4]  = mk(0, 0, 32'h0,        1, 0, 0, 16'h0000, 1, 16'h0001, 32'h11120001, 0, 0);
      vecs[5]  = mk(0, 0, 32'h0,        0, 0, 0, 16'h0000, 1, 16'h0001, 32'h11120001, 0, 0);
      vecs[6]  = mk(0, 0, 32'h0,        0, 0, 0, 16'h0000, 1, 16'h0001, 32'h11120001, 0, 0);
      vecs[7]  = mk(0, 0, 32'h0,        0, 0, 0, 16'h0000, 1, 16'h0001, 32'h11120001, 0, 0);
      vecs[8]  = mk(0, 1, 32'h20000000, 0, 0, 0, 16'h0000, 0, 16'h0002, 32'h20000000, 1, 0);
      vecs[9]  = mk(0, 1, 32'h0BAD0BAD, 0, 0, 0, 16'h0000, 0, 16'h0002, 32'h20000000, 1, 0);
      vecs[10] = mk(0, 0, 32'h0,        0, 1, 0, 16'h0100, 0, 16'h0002, 32'h20000000, 1, 0);
      vecs[11] = mk(0, 0, 32'h0,        1, 1, 0, 16'h0004, 1, 16'h0004, 32'h20000000, 0, 0);
      vecs[12] = mk(0, 1, 32'h30000000, 0, 0, 0, 16'h0000, 0, 16'h0005, 32'h30000000, 1, 0);
      vecs[13] = mk(0, 0, 32'h0,        1, 1, 1, 16'hFFFD, 1, 16'h0002, 32'h30000000, 0, 0);
      vecs[14] = mk(0, 1, 32'h40000000, 0, 0, 0, 16'h0000, 0, 16'h0003, 32'h40000000, 1, 0);
      vecs[15] = mk(0, 0, 32'h0,        1, 1, 0, 16'h0040, 1, 16'h0040, 32'h40000000, 0, 0);
      vecs[16] = mk(0, 1, 32'h50000000, 0, 0, 0, 16'h0000, 0, 16'h0041, 32'h50000000, 1, 0);
      vecs[17] = mk(0, 0, 32'h0,        1, 1, 0, 16'hFFFF, 1, 16'hFFFF, 32'h50000000, 0, 0);
      vecs[18] = mk(0, 1, 32'h60000000, 0, 0, 0, 16'h0000, 0, 16'h0000, 32'h60000000, 1, 0);
      vecs[19] = mk(0, 0, 32'h0,        1, 1, 0, 16'hFFFE, 1, 16'hFFFE, 32'h60000000, 0, 0);
      vecs[20] = mk(0, 1, 32'h70000000, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 32'h70000000, 1, 0);
      vecs[21] = mk(0, 0, 32'h0,        1, 1, 1, 16'h0002, 1, 16'h0001, 32'h70000000, 0, 0);
      vecs[22] = mk(0, 0, 32'h0,        1, 1, 0, 16'h0100, 1, 16'h0001, 32'h70000000, 0, 0);
      vecs[23] = mk(0, 1, 32'hF0000000, 0, 0, 0, 16'h0000, 0, 16'h0002, 32'hF0000000, 1, 0);
      vecs[24] = mk(0, 0, 32'h0,        1, 1, 0, 16'h0080, 0, 16'h0002, 32'hF0000000, 0, 1);

      #2;
      for (int i = 0; i < 25; i++) begin
         rst_f = vecs[i].rst;  imem_ack = vecs[i].ack; imem_data = vecs[i].data;
         instr_done = vecs[i].done; br_taken = vecs[i].bt; br_rel = vecs[i].rel;
         br_target = vecs[i].tgt;
         step();
         check($sformatf("v%0d imem_req", i),    32'(imem_req),    32'(vecs[i].req));
         check($sformatf("v%0d pc_out", i),      32'(pc_out),      32'(vecs[i].pc));
         check($sformatf("v%0d imem_addr", i),   32'(imem_addr),   32'(vecs[i].pc));
         check($sformatf("v%0d instruction", i), instruction,      vecs[i].ir);
         check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
         check($sformatf("v%0d halted", i),      32'(halted),      32'(vecs[i].hlt));
         check($sformatf("v%0d fetch_err", i),   32'(fetch_err),   32'h0);
      end

      // Halted: acks and done pulses must not restart fetch.
      for (int i = 0; i < 20; i++) begin
         imem_ack = 1'b1; imem_data = 32'h12345678; instr_done = i[0]; br_taken = 1'b1;
         step();
         check($sformatf("halt%0d imem_req", i), 32'(imem_req), 32'h0);
         check($sformatf("halt%0d pc_out", i),   32'(pc_out),   32'h0002);
         check($sformatf("halt%0d halted", i),   32'(halted),   32'h1);
      end

      // Reset recovers from halt.
      rst_f = 1'b1; imem_ack = 1'b0; instr_done = 1'b0; br_taken = 1'b0;
      step();
      check("rst halted", 32'(halted), 32'h0);
      check("rst pc_out", 32'(pc_out), 32'h0);
      check("rst instruction", instruction, 32'h0);
      check("rst imem_req", 32'(imem_req), 32'h0);
      rst_f = 1'b0;
      step();
      check("restart imem_req", 32'(imem_req), 32'h1);
      check("restart imem_addr", 32'(imem_addr), 32'h0);

      // No ack: 15 request cycles total including the one above.
      for (int i = 0; i < 14; i++) begin
         step();
         check($sformatf("wait%0d imem_req", i), 32'(imem_req), 32'h1);
         check($sformatf("wait%0d fetch_err", i), 32'(fetch_err), 32'h0);
      end
      step();
`ifdef FETCH_TIMEOUT_EN
      check("tmo fetch_err", 32'(fetch_err), 32'h1);
      check("tmo imem_req low", 32'(imem_req), 32'h0);
      check("tmo imem_addr", 32'(imem_addr), 32'h0);
      imem_ack = 1'b1; imem_data = 32'h99999999;
      step();
      check("tmo ack ignored", instruction, 32'h0);
      check("tmo reissue req", 32'(imem_req), 32'h1);
      check("tmo reissue addr", 32'(imem_addr), 32'h0);
      imem_data = 32'h21000000;
      step();
      check("tmo ack instruction", instruction, 32'h21000000);
      check("tmo err sticky", 32'(fetch_err), 32'h1);
`else
      check("notmo fetch_err", 32'(fetch_err), 32'h0);
      check("notmo imem_req", 32'(imem_req), 32'h1);
      imem_ack = 1'b1; imem_data = 32'h21000000;
      step();
      check("notmo ack instruction", instruction, 32'h21000000);
      check("notmo pc_out", 32'(pc_out), 32'h0001);
`endif
      imem_ack = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
